axi_rd_responder: RTL
=====================

Name: axi_rd_responder

Overview:
- Slave-side AXI3-style read responder: the target end of the read address channel whose entries the master side queues (id, addr, len, size, burst, lock, cache, prot).
- Accepts AR requests, walks the burst address sequence (FIXED/INCR/WRAP) and reads a synchronous 1-cycle-latency memory port.
- Returns R beats with RID/RRESP/RLAST under full RREADY backpressure.
- Sits between the interconnect and the on-chip memory model.

Parameters:
- TAG_BITS, 2, width of ARID/RID
- ADDR_W, 32, address width
- DATA_W, 32, data width; 32 or 64 only

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- arvalid  in  1  AR valid
- arready  out  1  AR ready
- arid  in  TAG_BITS  request ID
- araddr  in  ADDR_W  start byte address
- arlen  in  4  beats-1
- arsize  in  2  log2 bytes per beat
- arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- arlock  in  2  accepted, ignored
- arcache  in  4  accepted, ignored
- arprot  in  3  accepted, ignored
- rvalid  out  1  R valid
- rready  in  1  R ready
- rid  out  TAG_BITS  ID of the current burst
- rdata  out  DATA_W  read data
- rresp  out  2  00 OKAY, 10 SLVERR
- rlast  out  1  final beat
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  ADDR_W  byte address, low log2(DATA_W/8) bits zero
- mem_rdata  in  DATA_W  valid one cycle after mem_rd_en

Behaviour:
- Reset (rst low, async): state IDLE, arready=1, rvalid=0, rlast=0, rdata=0, rid=0, rresp=0, mem_rd_en=0, beat counter=0. Takes effect immediately, including mid-burst; the burst in progress is dropped with no further beats.
- FSM IDLE -> READ -> DATA -> (READ | IDLE).
- IDLE:
  - arready=1.
  - On arvalid&arready, capture all AR fields, set cur_addr=araddr, beat_cnt=0, then go to READ.
  - Error check at capture: err=1 if arburst==11, or 2^arsize > DATA_W/8, or (WRAP and arlen not in {1,3,7,15}).
- READ:
  - arready=0.
  - If !err: mem_rd_en=1 for exactly one cycle, mem_addr=cur_addr with its word-offset bits cleared.
  - If err: mem_rd_en stays 0.
  - Always go to DATA.
- DATA:
  - rvalid=1.
  - rdata = mem_rdata captured on the DATA-entry edge, or 0 if err.
  - rresp = SLVERR if err, else OKAY.
  - rid = captured ID.
  - rlast = (beat_cnt==len).
  - All R outputs stay stable while rready=0.
  - On rvalid&rready: if rlast, go to IDLE. Otherwise beat_cnt+1, cur_addr=next_addr, go to READ.
- next_addr, with bytes = 1<<size:
  - FIXED: cur_addr.
  - INCR: align(cur_addr,size)+bytes, modulo 2^ADDR_W (wrap-around allowed, no 4KB check).
  - WRAP: wsize=(len+1)*bytes; base=cur_addr & ~(wsize-1); next = base | ((cur_addr+bytes) & (wsize-1)).
- Throughput: 2 cycles per beat minimum. First rvalid appears 2 cycles after the AR handshake edge.
- rvalid never deasserts without a handshake. Exactly len+1 beats per request, including error bursts.

Optional Feature:
- Macro: AXI_RD_AR_BUF_EN.
- Defined:
  - Adds a one-entry AR holding register. arready = !holding_full in every state.
  - A request accepted during a burst starts its READ on the cycle after the current burst's final handshake (no IDLE bubble).
  - A request arriving while the holding register is full waits (arready=0).
  - Reset clears the holding register.
- Undefined: arready=1 only in IDLE. Behaviour is exactly as specified above.

Decomposition:
- Package axi_pkg holds:
  - burst encodings BURST_FIXED/INCR/WRAP
  - RESP_OKAY/RESP_SLVERR
  - FSM state typedef
  - AR field widths (LEN_W=4, SIZE_W=2, LOCK_W=2, CACHE_W=4, PROT_W=3)
- Sub-module axi_burst_addr_gen: purely combinational next_addr from (cur_addr, len, size, burst). It is reused by the write-side responder.

Test Plan:
- INCR, id=2, addr=0x100, len=3, size=2: mem_addr 0x100,0x104,0x108,0x10C; 4 beats rid=2, OKAY; rlast on beat 4 only.
- WRAP, addr=0x108, len=3, size=2: mem_addr 0x108,0x10C,0x100,0x104; rlast on the 0x104 beat.
- FIXED, addr=0x20, len=2: three reads all at 0x20; 3 beats.
- rready held low 5 cycles on beat 2 of an INCR burst: rvalid, rdata, rlast stable; no extra mem_rd_en; burst completes after rready rises.
- arburst=11, len=1: 2 beats, rresp=10, rdata=0, mem_rd_en never asserted; also size=3 with DATA_W=32 gives the same result.
- rst low mid-burst on beat 2 of 4: rvalid=0 and arready=1 immediately. After release, a new INCR request at 0x0 returns beats from 0x0.

Source files
------------

// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_pkg
// Description : Shared AXI3 read/write-side definitions. It holds the burst
//               and response encodings, the responder FSM state type, the AR
//               field widths, and the AR request legality check.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_pkg;

    localparam int LEN_W   = 4;
    localparam int SIZE_W  = 2;
    localparam int LOCK_W  = 2;
    localparam int CACHE_W = 4;
    localparam int PROT_W  = 3;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DATA = 2'd2
    } rd_state_e;

    // A request is answered with SLVERR when it uses the reserved burst type,
    // asks for a beat wider than the bus, or is a WRAP with an illegal length.
    function automatic logic ar_is_err(input logic [1:0]        burst,
                                       input logic [SIZE_W-1:0] size,
                                       input logic [LEN_W-1:0]  len,
                                       input int unsigned       bus_bytes);
        logic bad_wrap;
        bad_wrap = (burst == BURST_WRAP) &&
                   !((len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15));
        return (burst == 2'b11) || ((32'd1 << size) > bus_bytes) || bad_wrap;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_burst_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : axi_burst_addr_gen
// Description : Combinational next-beat address for AXI FIXED/INCR/WRAP bursts.
//               This module is shared by the read and write responders.
// Ports       : cur_addr_i  - address of the current beat
//               len_i       - burst length minus one
//               size_i      - log2 of bytes per beat
//               burst_i     - burst type
//               next_addr_o - address of the following beat
// Revision    : 1.0 - initial release
// ============================================================================
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0]  cur_addr_i,
    input  logic [LEN_W-1:0]   len_i,
    input  logic [SIZE_W-1:0]  size_i,
    input  logic [1:0]         burst_i,
    output logic [ADDR_W-1:0]  next_addr_o
);

    logic [ADDR_W-1:0] w_bytes;
    logic [ADDR_W-1:0] w_aligned;
    logic [ADDR_W-1:0] w_wmask;

    assign w_bytes   = ADDR_W'(1) << size_i;
    assign w_aligned = cur_addr_i & ~(w_bytes - ADDR_W'(1));
    // The wrap window is (len+1)*bytes. It is a power of two for every legal WRAP length.
    assign w_wmask   = ((ADDR_W'(len_i) + ADDR_W'(1)) << size_i) - ADDR_W'(1);

    always_comb begin
        next_addr_o = cur_addr_i;
        case (burst_i)
            BURST_FIXED: next_addr_o = cur_addr_i;
            BURST_INCR:  next_addr_o = w_aligned + w_bytes;
            BURST_WRAP:  next_addr_o = (cur_addr_i & ~w_wmask) |
                                       ((cur_addr_i + w_bytes) & w_wmask);
            default:     next_addr_o = cur_addr_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/axi_rd_responder.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_responder
// Description : AXI3 slave read responder. It accepts AR requests and walks
//               the burst addresses. For each beat it issues one read to a
//               synchronous memory with a latency of one cycle, then returns
//               that beat on the R channel under RREADY backpressure.
//               Each beat takes a READ cycle (memory strobe) followed by a
//               DATA cycle or cycles (rvalid held until the handshake).
// Ports       : clk, rst (async, active-low)
//               AR channel : arvalid_i/arready_o, arid_i, araddr_i, arlen_i,
//                            arsize_i, arburst_i, arlock_i, arcache_i, arprot_i
//               R channel  : rvalid_o/rready_i, rid_o, rdata_o, rresp_o, rlast_o
//               Memory     : mem_rd_en_o, mem_addr_o, mem_rdata_i
// Config      : AXI_RD_AR_BUF_EN - adds a one-entry AR holding register. A
//               request accepted during a burst starts as soon as that burst
//               completes.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_rd_responder
    import axi_pkg::*;
#(
    parameter int TAG_BITS = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                arvalid_i,
    output logic                arready_o,
    input  logic [TAG_BITS-1:0] arid_i,
    input  logic [ADDR_W-1:0]   araddr_i,
    input  logic [LEN_W-1:0]    arlen_i,
    input  logic [SIZE_W-1:0]   arsize_i,
    input  logic [1:0]          arburst_i,
    input  logic [LOCK_W-1:0]   arlock_i,
    input  logic [CACHE_W-1:0]  arcache_i,
    input  logic [PROT_W-1:0]   arprot_i,
    output logic                rvalid_o,
    input  logic                rready_i,
    output logic [TAG_BITS-1:0] rid_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic [1:0]          rresp_o,
    output logic                rlast_o,
    output logic                mem_rd_en_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    localparam int unsigned     BUS_BYTES = DATA_W / 8;
    localparam logic [ADDR_W-1:0] WORD_MASK = ~(ADDR_W'(BUS_BYTES - 1));

    rd_state_e           state_q;
    logic                arready_q, rvalid_q, rlast_q, mem_rd_en_q;
    logic                first_q, err_q;
    logic [TAG_BITS-1:0] rid_q;
    logic [1:0]          rresp_q;
    logic [ADDR_W-1:0]   cur_addr_q, mem_addr_q;
    logic [LEN_W-1:0]    len_q, beat_q;
    logic [SIZE_W-1:0]   size_q;
    logic [1:0]          burst_q;
    logic [DATA_W-1:0]   rdata_q;

    logic                w_ar_hs, w_final, w_start, w_arready_d, w_port_err;
    logic [TAG_BITS-1:0] w_src_id;
    logic [ADDR_W-1:0]   w_src_addr, w_next_addr;
    logic [LEN_W-1:0]    w_src_len;
    logic [SIZE_W-1:0]   w_src_size;
    logic [1:0]          w_src_burst;
    logic                w_src_err;

    // lock/cache/prot carry no meaning for an on-chip memory target.
    logic w_unused;
    assign w_unused = ^{arlock_i, arcache_i, arprot_i};

    assign w_ar_hs    = arvalid_i && arready_q;
    assign w_final    = (state_q == ST_DATA) && rready_i && rlast_q;
    assign w_port_err = ar_is_err(arburst_i, arsize_i, arlen_i, BUS_BYTES);

`ifdef AXI_RD_AR_BUF_EN
    logic                hold_full_q, hold_err_q;
    logic [TAG_BITS-1:0] hold_id_q;
    logic [ADDR_W-1:0]   hold_addr_q;
    logic [LEN_W-1:0]    hold_len_q;
    logic [SIZE_W-1:0]   hold_size_q;
    logic [1:0]          hold_burst_q;
    logic                w_use_hold, w_hold_load, w_hold_full_d;

    // The held request has priority at the end of a burst. A new request
    // that arrives on that same final edge goes straight into the FSM only
    // when the holding register is empty.
    assign w_use_hold    = w_final && hold_full_q;
    assign w_start       = ((state_q == ST_IDLE) && w_ar_hs) ||
                           (w_final && (hold_full_q || w_ar_hs));
    assign w_hold_load   = w_ar_hs && !(w_start && !w_use_hold);
    assign w_hold_full_d = w_hold_load || (hold_full_q && !w_use_hold);
    assign w_arready_d   = !w_hold_full_d;

    assign w_src_id    = w_use_hold ? hold_id_q    : arid_i;
    assign w_src_addr  = w_use_hold ? hold_addr_q  : araddr_i;
    assign w_src_len   = w_use_hold ? hold_len_q   : arlen_i;
    assign w_src_size  = w_use_hold ? hold_size_q  : arsize_i;
    assign w_src_burst = w_use_hold ? hold_burst_q : arburst_i;
    assign w_src_err   = w_use_hold ? hold_err_q   : w_port_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_full_q  <= 1'b0;
            hold_err_q   <= 1'b0;
            hold_id_q    <= '0;
            hold_addr_q  <= '0;
            hold_len_q   <= '0;
            hold_size_q  <= '0;
            hold_burst_q <= '0;
        end else begin
            hold_full_q <= w_hold_full_d;
            if (w_hold_load) begin
                hold_err_q   <= w_port_err;
                hold_id_q    <= arid_i;
                hold_addr_q  <= araddr_i;
                hold_len_q   <= arlen_i;
                hold_size_q  <= arsize_i;
                hold_burst_q <= arburst_i;
            end
        end
    end
`else
    assign w_start     = (state_q == ST_IDLE) && w_ar_hs;
    assign w_arready_d = w_start ? 1'b0 : (w_final ? 1'b1 : arready_q);

    assign w_src_id    = arid_i;
    assign w_src_addr  = araddr_i;
    assign w_src_len   = arlen_i;
    assign w_src_size  = arsize_i;
    assign w_src_burst = arburst_i;
    assign w_src_err   = w_port_err;
`endif

    axi_burst_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .cur_addr_i  (cur_addr_q),
        .len_i       (len_q),
        .size_i      (size_q),
        .burst_i     (burst_q),
        .next_addr_o (w_next_addr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            arready_q   <= 1'b1;
            rvalid_q    <= 1'b0;
            rlast_q     <= 1'b0;
            mem_rd_en_q <= 1'b0;
            first_q     <= 1'b0;
            err_q       <= 1'b0;
            rid_q       <= '0;
            rresp_q     <= RESP_OKAY;
            cur_addr_q  <= '0;
            mem_addr_q  <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            rdata_q     <= '0;
        end else begin
            arready_q   <= w_arready_d;
            mem_rd_en_q <= 1'b0;
            first_q     <= 1'b0;
            if (w_start) begin
                state_q     <= ST_READ;
                rid_q       <= w_src_id;
                cur_addr_q  <= w_src_addr;
                len_q       <= w_src_len;
                size_q      <= w_src_size;
                burst_q     <= w_src_burst;
                err_q       <= w_src_err;
                rresp_q     <= w_src_err ? RESP_SLVERR : RESP_OKAY;
                beat_q      <= '0;
                mem_rd_en_q <= !w_src_err;
                mem_addr_q  <= w_src_addr & WORD_MASK;
                rvalid_q    <= 1'b0;
                rlast_q     <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: ;
                    ST_READ: begin
                        state_q  <= ST_DATA;
                        rvalid_q <= 1'b1;
                        rlast_q  <= (beat_q == len_q);
                        first_q  <= 1'b1;
                    end
                    ST_DATA: begin
                        // Memory data is live in the first DATA cycle only. It is
                        // latched here so that a stalled beat stays stable.
                        if (first_q) begin
                            rdata_q <= mem_rdata_i;
                        end
                        if (rready_i) begin
                            rvalid_q <= 1'b0;
                            rlast_q  <= 1'b0;
                            if (rlast_q) begin
                                state_q <= ST_IDLE;
                            end else begin
                                state_q     <= ST_READ;
                                beat_q      <= beat_q + 4'd1;
                                cur_addr_q  <= w_next_addr;
                                mem_rd_en_q <= !err_q;
                                mem_addr_q  <= w_next_addr & WORD_MASK;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign arready_o   = arready_q;
    assign rvalid_o    = rvalid_q;
    assign rlast_o     = rlast_q;
    assign rid_o       = rid_q;
    assign rresp_o     = rresp_q;
    assign mem_rd_en_o = mem_rd_en_q;
    assign mem_addr_o  = mem_addr_q;
    assign rdata_o     = (rvalid_q && !err_q) ? (first_q ? mem_rdata_i : rdata_q) : '0;

endmodule
`default_nettype wire
